// File: rtl/mat_vec_mac_stream_if.sv
// Handshake bundle for the streaming matrix-vector MAC engine: job control,
// vector and matrix operand streams, and the result stream.
interface mat_vec_mac_stream_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int ROW_W  = 2
);
  logic                     start;
  logic                     keep_vec;
  logic                     vec_valid;
  logic                     vec_ready;
  logic signed [DATA_W-1:0] vec_data;
  logic                     mat_valid;
  logic                     mat_ready;
  logic signed [DATA_W-1:0] mat_data;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [OUT_W-1:0]  res_data;
  logic [ROW_W-1:0]         res_row;
  logic                     res_last;
  logic                     busy;
  logic                     vec_loaded;

  // Producer/consumer side (drives operands and accepts results)
  modport master (
    output start, keep_vec, vec_valid, vec_data, mat_valid, mat_data, res_ready,
    input  vec_ready, mat_ready, res_valid, res_data, res_row, res_last, busy, vec_loaded
  );

  // Engine side
  modport slave (
    input  start, keep_vec, vec_valid, vec_data, mat_valid, mat_data, res_ready,
    output vec_ready, mat_ready, res_valid, res_data, res_row, res_last, busy, vec_loaded
  );
endinterface

// File: rtl/mat_vec_mac_stream.sv
// Sequential signed matrix-vector multiplier: loads a NUM_COLS vector, then
// streams the matrix row-major through one MAC and emits one result per row.
// The stored vector survives across jobs so it can be reused with keep_vec.
module mat_vec_mac_stream #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 4,
  parameter int DATA_W   = 16,
  parameter int OUT_W    = 32,
  parameter int SAT      = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  mat_vec_mac_stream_if.slave io
);

  // Accumulator wide enough that a full row of products can never overflow
  localparam int ACC_W = 2 * DATA_W + $clog2(NUM_COLS) + 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_VEC,
    S_MAC,
    S_DRAIN
  } state_t;

  logic [1:0]               rst_sync_q;
  logic                     rst_int_n;
  state_t                   state_q;
  logic [COL_W-1:0]         col_cnt_q;
  logic [ROW_W-1:0]         row_cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     res_valid_q;
  logic signed [OUT_W-1:0]  res_data_q;
  logic [ROW_W-1:0]         res_row_q;
  logic                     res_last_q;
  logic                     vec_loaded_q;
  logic signed [DATA_W-1:0] vec_mem [NUM_COLS];

  logic                       mat_ready_d;
  logic                       mat_fire;
  logic                       res_fire;
  logic signed [2*DATA_W-1:0] prod_d;
  logic signed [ACC_W-1:0]    acc_base_d;
  logic signed [ACC_W-1:0]    acc_sum_d;
  logic signed [OUT_W-1:0]    res_conv_d;

  // Reset asserts asynchronously but releases two clocks later, in step with clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  // Handshake qualifiers; matrix beats stall while a result is waiting
  assign mat_ready_d = (state_q == S_MAC) && !res_valid_q;
  assign mat_fire    = mat_ready_d && io.mat_valid;
  assign res_fire    = res_valid_q && io.res_ready;

  // MAC datapath: first column of a row restarts the sum from zero
  always_comb begin
    prod_d     = io.mat_data * vec_mem[col_cnt_q];
    acc_base_d = (col_cnt_q == '0) ? '0 : acc_q;
    acc_sum_d  = acc_base_d + {{(ACC_W - 2*DATA_W){prod_d[2*DATA_W-1]}}, prod_d};
  end

  // Narrow the finished row sum to the output width: clamp or wrap
  generate
    if (SAT != 0) begin : g_sat
      always_comb begin
        if (acc_sum_d > SAT_MAX)      res_conv_d = SAT_MAX[OUT_W-1:0];
        else if (acc_sum_d < SAT_MIN) res_conv_d = SAT_MIN[OUT_W-1:0];
        else                          res_conv_d = acc_sum_d[OUT_W-1:0];
      end
    end else begin : g_wrap
      assign res_conv_d = acc_sum_d[OUT_W-1:0];
    end
  endgenerate

  // Vector storage: written only during LOAD_VEC, contents kept across jobs
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD_VEC && io.vec_valid) vec_mem[col_cnt_q] <= io.vec_data;
  end

  // Control FSM with counters, accumulator and the result holding register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= S_IDLE;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      acc_q        <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_row_q    <= '0;
      res_last_q   <= 1'b0;
      vec_loaded_q <= 1'b0;
    end else begin
      if (res_fire) res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (io.start) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            // A reuse request without a stored vector falls back to a load
            state_q   <= (io.keep_vec && vec_loaded_q) ? S_MAC : S_LOAD_VEC;
          end
        end
        S_LOAD_VEC: begin
          if (io.vec_valid) begin
            if (col_cnt_q == LAST_COL) begin
              col_cnt_q    <= '0;
              vec_loaded_q <= 1'b1;
              state_q      <= S_MAC;
            end else begin
              col_cnt_q <= col_cnt_q + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (mat_fire) begin
            acc_q <= acc_sum_d;
            if (col_cnt_q == LAST_COL) begin
              col_cnt_q   <= '0;
              res_valid_q <= 1'b1;
              res_data_q  <= res_conv_d;
              res_row_q   <= row_cnt_q;
              res_last_q  <= (row_cnt_q == LAST_ROW);
              if (row_cnt_q == LAST_ROW) begin
                row_cnt_q <= '0;
                state_q   <= S_DRAIN;
              end else begin
                row_cnt_q <= row_cnt_q + 1'b1;
              end
            end else begin
              col_cnt_q <= col_cnt_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (res_fire) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.vec_ready  = (state_q == S_LOAD_VEC);
  assign io.mat_ready  = mat_ready_d;
  assign io.res_valid  = res_valid_q;
  assign io.res_data   = res_data_q;
  assign io.res_row    = res_row_q;
  assign io.res_last   = res_last_q;
  assign io.busy       = (state_q != S_IDLE);
  assign io.vec_loaded = vec_loaded_q;

endmodule

// File: doc/mat_vec_mac_stream.md
# mat_vec_mac_stream

Streaming, parametrised signed fixed-point matrix-vector multiplier that generalises the combinational matrix-vector multiplier into a sequential, handshaked engine. It loads a NUM_COLS-element vector and then consumes the matrix row-major, one element per cycle, on a single MAC. It emits one NUM_ROWS-indexed dot-product result per row. It sits between operand-fetch streams and the result consumer, and can reuse a loaded vector across jobs.

## Interface
- NUM_ROWS, default 3: matrix rows, which is also the number of results per job; ≥1.
- NUM_COLS, default 4: matrix columns and vector length; ≥1.
- DATA_W, default 16: signed two's-complement operand width.
- OUT_W, default 32: signed result width; must be ≤ ACC_W.
- SAT, default 1: 1 = saturate result to OUT_W; 0 = wrap (keep low OUT_W bits).
- ACC_W, derived: 2*DATA_W + $clog2(NUM_COLS)+1, internal accumulator width; it never overflows.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job request; sampled only in IDLE.
- keep_vec  in  1  sampled with start; 1 = skip vector load and reuse the stored vector.
- vec_valid / vec_ready  in/out  1  vector stream handshake.
- vec_data  in  DATA_W  vector element, index 0 first.
- mat_valid / mat_ready  in/out  1  matrix stream handshake.
- mat_data  in  DATA_W  matrix element, row-major order.
- res_valid / res_ready  out/in  1  result handshake.
- res_data  out  OUT_W  dot product of the current row.
- res_row  out  $clog2(NUM_ROWS) (min 1)  row index of res_data.
- res_last  out  1  high with the final row's result.
- busy  out  1  high in any state other than IDLE.
- vec_loaded  out  1  a complete vector is stored since reset.

## Operation
- A transfer occurs on a rising edge with valid&ready both high.
- FSM states: IDLE, LOAD_VEC, MAC, DRAIN.
- IDLE:
  - start=1 with keep_vec=0 → LOAD_VEC.
  - start=1 with keep_vec=1 and vec_loaded=1 → MAC.
  - start=1 with keep_vec=1 and vec_loaded=0 → treated as keep_vec=0.
- LOAD_VEC: vec_ready=1. Each transfer writes vec_data to slot col_cnt, and col_cnt advances. After transfer NUM_COLS-1: col_cnt clears, vec_loaded sets, and the FSM goes to MAC.
- MAC: mat_ready = !res_valid.
  - Each transfer: acc ← (col_cnt==0 ? 0 : acc) + mat_data*vec[col_cnt], full signed ACC_W arithmetic.
  - On transfer col_cnt==NUM_COLS-1: the converted acc is loaded into res_data, res_valid sets, col_cnt clears, and row_cnt advances.
  - After the last row's final element, the FSM goes to DRAIN.
- Conversion:
  - SAT=1 clamps acc to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SAT=0 takes acc[OUT_W-1:0].
- Result register: res_data, res_row and res_last hold stable while res_valid=1 and res_ready=0. res_valid clears on a transfer unless a new result loads in the same edge; a new result cannot load there, because mat_ready is low while res_valid=1.
- DRAIN: waits for the last result transfer, then goes to IDLE with busy=0 in the next cycle.
- start, keep_vec, vec_valid and mat_valid outside their accepting states are ignored. No beats are consumed outside those states.
- The vector register persists across jobs. It is only rewritten in LOAD_VEC, and it is not cleared by job completion.

## Timing
- Reset (async assert, synchronous release internally): FSM=IDLE; all outputs 0, namely ready signals, res_valid, res_data, res_row, res_last, busy and vec_loaded. Counters and acc are 0. Vector contents are don't-care.
- Reset asserted mid-job aborts immediately. The partial result is discarded, and vec_loaded=0, so the next job must load a vector.
- start edge in IDLE → busy=1 and vec_ready (or mat_ready) =1 on the following cycle.
- Vector load: minimum NUM_COLS cycles.
- Last element of a row accepted at edge t → res_valid=1 from t.
- With res_ready tied high, throughput is one matrix element per cycle, except for one bubble per row while res_valid is high.
- Minimum job length with res_ready=1: NUM_COLS + NUM_ROWS*(NUM_COLS+1) cycles after start. Without the vector load (keep_vec=1): NUM_ROWS*(NUM_COLS+1).
- Single-element degenerate case, NUM_COLS=1: every matrix beat produces a result.

## Test plan
- Basic, defaults: vector 30,28,26,24; matrix 1..12 row-major; res_ready=1 → results 260, 692, 1124 with rows 0, 1, 2; res_last only on 1124; busy drops 1 cycle after the final transfer.
- Backpressure: same stimulus, res_ready held 0 for 5 cycles after the first result → res_data=260 stable, mat_ready=0 throughout, no matrix beat lost; final results identical.
- Vector reuse: after the basic job, start with keep_vec=1 and matrix rows (1,0,0,0), (0,1,0,0), (0,0,1,0) → no vec_ready pulse; results 30, 28, 26.
- Saturation, DATA_W=16, OUT_W=16:
  - SAT=1, all operands 32767 → 32767.
  - SAT=1, matrix -32768 with vector 32767 → -32768.
  - SAT=0, all operands 32767 → 4 (0xFFFC0004 wrapped).
- Reset mid-job: assert rst_n=0 after 6 matrix beats → all outputs 0 the same cycle. Next start with keep_vec=1 performs a full vector load, and basic results repeat.
- Ignored inputs: start pulsed during MAC, and mat_valid high during LOAD_VEC → no state change, no extra beats consumed, results unchanged.
